// File: rtl/xbox_pkg.sv
// Shared definitions for the xbox host register block.
//   XBOX_NUM_HOST_REGS : width of the host register port arrays
//   xbox_word_t        : one 32-bit register word
//   xbox_state_e       : APB slave FSM state
package xbox_pkg;

    localparam int XBOX_NUM_HOST_REGS = 32;

    typedef logic [31:0] xbox_word_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_DONE = 2'd2
    } xbox_state_e;

endpackage

// File: rtl/xbox_status_capture.sv
// Sticky capture of one accelerator status word.
//   clk, rst      : clock, synchronous active-high reset
//   capture       : accelerator valid strobe for this register
//   clear         : good host write to this register (takes priority)
//   data_in       : accelerator-supplied value
//   status        : last captured value
//   status_valid  : set on capture, cleared by host write or reset
module xbox_status_capture
    import xbox_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic       clear,
    input  xbox_word_t data_in,
    output xbox_word_t status,
    output logic       status_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            status       <= '0;
            status_valid <= 1'b0;
        end else if (clear) begin
            // A host write in the same cycle as a capture wins.
            status_valid <= 1'b0;
        end else if (capture) begin
            status       <= data_in;
            status_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/xbox_host_regs_apb.sv
// APB slave exposing up to 32 host registers to software.
//   clk, rst              : clock, synchronous active-high reset
//   psel/penable/pwrite   : APB control
//   paddr, pwdata         : byte address (index = paddr[6:2]), write data
//   prdata/pready/pslverr : APB response; writes complete with no wait
//                           state, reads with exactly one
//   host_regs             : last SW-written value per register
//   host_regs_valid_pulse : one-cycle strobe, coincident with new value
//   host_regs_data_out    : accelerator status per register
//   host_regs_valid_out   : accelerator status strobe per register
module xbox_host_regs_apb
    import xbox_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     psel,
    input  logic                                     penable,
    input  logic                                     pwrite,
    input  logic [ADDR_W-1:0]                        paddr,
    input  logic [31:0]                              pwdata,
    output logic [31:0]                              prdata,
    output logic                                     pready,
    output logic                                     pslverr,
    output logic [XBOX_NUM_HOST_REGS-1:0][31:0]      host_regs,
    output logic [XBOX_NUM_HOST_REGS-1:0]            host_regs_valid_pulse,
    input  logic [XBOX_NUM_HOST_REGS-1:0][31:0]      host_regs_data_out,
    input  logic [XBOX_NUM_HOST_REGS-1:0]            host_regs_valid_out
);

    xbox_state_e                           state;
    logic        [4:0]                     idx;
    logic                                  addr_err;
    logic                                  acc_cycle;
    logic                                  wr_done;
    logic                                  wr_good;
    logic                                  rd_err;
    logic        [XBOX_NUM_HOST_REGS-1:0]  wr_clear;
    xbox_word_t  [XBOX_NUM_HOST_REGS-1:0]  status;
    logic        [XBOX_NUM_HOST_REGS-1:0]  status_valid;
    xbox_word_t                            rd_word;

    assign idx = paddr[6:2];

    // Misaligned, beyond the implemented registers, or outside the 128-byte window.
    assign addr_err = (paddr[1:0] != 2'b00) ||
                      (32'(idx) >= NUM_REGS) ||
                      (|(paddr >> 7));

    assign acc_cycle = (state == ST_ACCESS) && psel && penable;
    assign wr_done   = acc_cycle && pwrite;
    assign wr_good   = wr_done && !addr_err;
    assign wr_clear  = wr_good ? (32'd1 << idx) : '0;

    // Status overrides the SW value once the accelerator has posted one.
    assign rd_word = status_valid[idx] ? status[idx] : host_regs[idx];

    // Writes must finish in the access cycle itself, so their pready/pslverr
    // are decoded from the live bus; read responses come from RD_DONE.
    assign pready  = wr_done || (state == ST_RD_DONE);
    assign pslverr = (wr_done && addr_err) || ((state == ST_RD_DONE) && rd_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= ST_IDLE;
            host_regs             <= '0;
            host_regs_valid_pulse <= '0;
            prdata                <= '0;
            rd_err                <= 1'b0;
        end else begin
            // prdata/rd_err live for the single RD_DONE cycle only.
            host_regs_valid_pulse <= '0;
            prdata                <= '0;
            rd_err                <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (penable) begin
                        if (pwrite) begin
                            state <= ST_IDLE;
                            if (!addr_err) begin
                                host_regs[idx]             <= pwdata;
                                host_regs_valid_pulse[idx] <= 1'b1;
                            end
                        end else begin
                            state  <= ST_RD_DONE;
                            prdata <= addr_err ? 32'd0 : rd_word;
                            rd_err <= addr_err;
                        end
                    end
                end
                ST_RD_DONE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < XBOX_NUM_HOST_REGS; i++) begin : g_reg
        if (i < NUM_REGS) begin : g_impl
            xbox_status_capture u_cap (
                .clk          (clk),
                .rst          (rst),
                .capture      (host_regs_valid_out[i]),
                .clear        (wr_clear[i]),
                .data_in      (host_regs_data_out[i]),
                .status       (status[i]),
                .status_valid (status_valid[i])
            );
        end else begin : g_none
            assign status[i]       = '0;
            assign status_valid[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_xbox_host_regs_apb.sv
module tb_xbox_host_regs_apb;

    logic              clk = 1'b0;
    logic              rst;
    logic              psel, penable, pwrite;
    logic [11:0]       paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready, pslverr;
    logic [31:0][31:0] host_regs;
    logic [31:0]       host_regs_valid_pulse;
    logic [31:0][31:0] host_regs_data_out;
    logic [31:0]       host_regs_valid_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [31:0] m_regs [32];
    logic [31:0] m_stat [32];
    bit          m_sv   [32];

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rd_exp_t;
    rd_exp_t sb[$];

    always #5 clk = ~clk;

    xbox_host_regs_apb #(.ADDR_W(12), .NUM_REGS(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .psel                  (psel),
        .penable               (penable),
        .pwrite                (pwrite),
        .paddr                 (paddr),
        .pwdata                (pwdata),
        .prdata                (prdata),
        .pready                (pready),
        .pslverr               (pslverr),
        .host_regs             (host_regs),
        .host_regs_valid_pulse (host_regs_valid_pulse),
        .host_regs_data_out    (host_regs_data_out),
        .host_regs_valid_out   (host_regs_valid_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [11:0] a);
        return (a[1:0] != 2'b00) || (a >= 12'd128) || ((a >> 2) >= 12'd32);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_regs[k] = '0; m_stat[k] = '0; m_sv[k] = 1'b0;
        end
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d,
                          input bit cap_en, input int ci, input logic [31:0] cd);
        bit          err;
        int          i;
        logic [31:0] pv;
        err = is_err(a);
        i   = int'(a[6:2]);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        if (cap_en) begin
            host_regs_valid_out[ci] = 1'b1;
            host_regs_data_out[ci]  = cd;
        end
        #1;
        chk("wr_pready", 32'(pready), 32'd1);
        chk("wr_pslverr", 32'(pslverr), 32'(err));
        chk("wr_prdata", prdata, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; host_regs_valid_out = '0;
        if (cap_en) begin
            m_stat[ci] = cd; m_sv[ci] = 1'b1;
        end
        pv = '0;
        if (!err) begin
            m_regs[i] = d; m_sv[i] = 1'b0; pv[i] = 1'b1;
        end
        chk("wr_reg", host_regs[i], m_regs[i]);
        chk("wr_pulse", host_regs_valid_pulse, pv);
        chk("wr_pready_low", 32'(pready), 32'd0);
        @(posedge clk); #1;
        chk("wr_pulse_clr", host_regs_valid_pulse, 32'd0);
    endtask

    task automatic apb_rd(input logic [11:0] a);
        rd_exp_t e, got;
        int      waits;
        int      i;
        i      = int'(a[6:2]);
        e.err  = is_err(a);
        e.data = e.err ? 32'd0 : (m_sv[i] ? m_stat[i] : m_regs[i]);
        sb.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        chk("rd_wait_pready", 32'(pready), 32'd0);
        chk("rd_wait_prdata", prdata, 32'd0);
        waits = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            waits++;
            if (pready) break;
        end
        chk("rd_wait_states", 32'(waits), 32'd1);
        if (sb.size() == 0) begin
            chk("rd_sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk("rd_prdata", prdata, got.data);
            chk("rd_pslverr", 32'(pslverr), 32'(got.err));
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("rd_prdata_clr", prdata, 32'd0);
    endtask

    task automatic cap_pulse(input int ci, input logic [31:0] cd);
        @(posedge clk); #1;
        host_regs_valid_out[ci] = 1'b1;
        host_regs_data_out[ci]  = cd;
        @(posedge clk); #1;
        host_regs_valid_out = '0;
        m_stat[ci] = cd; m_sv[ci] = 1'b1;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        host_regs_data_out = '0; host_regs_valid_out = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pulse", host_regs_valid_pulse, 32'd0);
        chk("rst_regs", 32'(|host_regs), 32'd0);
        rst = 1'b0;

        // Basic write, then write/read-back
        apb_wr(12'h000, 32'h1, 1'b0, 0, 32'h0);
        apb_wr(12'h00C, 32'hA5, 1'b0, 0, 32'h0);
        apb_rd(12'h00C);

        // Status capture overrides, host write clears it
        cap_pulse(0, 32'h1);
        apb_rd(12'h000);
        cap_pulse(7, 32'h1234_5678);
        apb_rd(12'h01C);
        apb_wr(12'h000, 32'hCAFE_0001, 1'b0, 0, 32'h0);
        apb_rd(12'h000);

        // Write and capture on the same index in the same cycle: write wins
        apb_wr(12'h014, 32'h0000_5555, 1'b1, 5, 32'hDEAD);
        apb_rd(12'h014);

        // Capture on another index during a bus write proceeds independently
        apb_wr(12'h024, 32'h0909_0909, 1'b1, 10, 32'hBEEF_0010);
        apb_rd(12'h028);
        apb_rd(12'h024);

        // Boundary index
        apb_wr(12'h07C, 32'hFFFF_FFFF, 1'b0, 0, 32'h0);
        apb_rd(12'h07C);

        // Error accesses
        apb_wr(12'h002, 32'h1111_2222, 1'b0, 0, 32'h0);
        apb_wr(12'h080, 32'h3333_4444, 1'b0, 0, 32'h0);
        apb_rd(12'h002);
        apb_rd(12'h080);
        apb_rd(12'h000);

        // psel dropped after setup: no side effects
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        psel = 1'b0;
        @(posedge clk); #1;
        chk("drop_pulse", host_regs_valid_pulse, 32'd0);
        chk("drop_reg", host_regs[2], m_regs[2]);
        @(posedge clk); #1;
        chk("drop_pulse2", host_regs_valid_pulse, 32'd0);
        apb_rd(12'h008);

        // Reset during the read wait state
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h01C;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        chk("rstrd_wait", 32'(pready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        model_reset();
        chk("rstrd_pready", 32'(pready), 32'd0);
        chk("rstrd_prdata", prdata, 32'd0);
        chk("rstrd_regs", 32'(|host_regs), 32'd0);
        chk("rstrd_pulse", host_regs_valid_pulse, 32'd0);
        apb_rd(12'h01C);
        apb_rd(12'h028);
        apb_rd(12'h00C);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
